// File: rtl/serial_sub_sequencer_pkg.sv
// Shared encodings for the bit-serial subtract/decrement unit.
// Holds the FSM state type and the mode select constants.
package serial_sub_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/serial_sub_sequencer_full_subtractor.sv
// One-bit full-subtractor cell: diff = min - sub - bin, with borrow out.
module full_subtractor (
  input  logic min,
  input  logic sub,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic w_x;

  assign w_x  = min ^ sub;
  assign diff = w_x ^ bin;
  assign bout = (~min & sub) | (~w_x & bin);

endmodule

// File: rtl/serial_sub_sequencer.sv
// Bit-serial A-B / A-1 unit: one full-subtractor cell sequenced LSB first
// across WIDTH bits, with a start/busy/done handshake.
module serial_sub_sequencer
  import serial_sub_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             bout,
  output logic             zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic             r_borrow_ff;
  logic [CNT_W-1:0] r_cnt;

  logic             w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_next_result;

  full_subtractor u_cell (
    .min  (r_a_sr[0]),
    .sub  (r_b_sr[0]),
    .bin  (r_borrow_ff),
    .diff (w_diff),
    .bout (w_borrow)
  );

  // Result fills from the MSB so after WIDTH shifts the LSB-first bits land in place.
  assign w_next_result = {w_diff, result[WIDTH-1:1]};

  // NOTE: every register here updates with <= so all reads in this block see
  // pre-edge values, matching the hardware flip-flops regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_a_sr      <= '0;
      r_b_sr      <= '0;
      r_borrow_ff <= 1'b0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      bout        <= 1'b0;
      zero        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a_sr      <= a;
            r_b_sr      <= (mode == MODE_DEC) ? '0 : b;
            r_borrow_ff <= mode;
            r_cnt       <= '0;
            busy        <= 1'b1;
            r_state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          result      <= w_next_result;
          r_a_sr      <= r_a_sr >> 1;
          r_b_sr      <= r_b_sr >> 1;
          r_borrow_ff <= w_borrow;
          r_cnt       <= r_cnt + 1'b1;
          if (r_cnt == LAST_BIT) begin
            bout    <= w_borrow;
            zero    <= (w_next_result == '0);
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_sequencer.sv
// Directed bench for serial_sub_sequencer: WIDTH=8 instance for the main
// cases plus a WIDTH=2 instance for the narrow-word boundary.
module tb_serial_sub_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, mode;
  logic [7:0] a, b;
  logic       busy, done, bout, zero;
  logic [7:0] result;

  logic       s2_start, s2_mode;
  logic [1:0] s2_a, s2_b;
  logic       s2_busy, s2_done, s2_bout, s2_zero;
  logic [1:0] s2_result;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_sub_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .bout(bout), .zero(zero)
  );

  serial_sub_sequencer #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(s2_start), .mode(s2_mode), .a(s2_a), .b(s2_b),
    .busy(s2_busy), .done(s2_done), .result(s2_result), .bout(s2_bout), .zero(s2_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge right after the accept edge; returns cycles until done
  // and how many of those samples showed busy.
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_op(input string tag, input logic m, input logic [7:0] av,
                       input logic [7:0] bv, input logic [7:0] exp_r,
                       input logic exp_bo, input logic exp_z);
    int cyc, bc;
    @(negedge clk);
    start = 1'b1; mode = m; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; mode = ~m; a = 8'($urandom); b = 8'($urandom);
    wait_done(cyc, bc);
    check({tag, " latency"}, cyc, 8);
    check({tag, " busy_cycles"}, bc, 8);
    check({tag, " busy_at_done"}, busy, 0);
    check({tag, " result"}, result, exp_r);
    check({tag, " bout"}, bout, exp_bo);
    check({tag, " zero"}, zero, exp_z);
    @(negedge clk);
    check({tag, " done_one_cycle"}, done, 0);
    check({tag, " result_held"}, result, exp_r);
  endtask

  initial begin
    int cyc, bc, extra, last_done, n_done;
    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    s2_start = 1'b0; s2_mode = 1'b0; s2_a = '0; s2_b = '0;
    repeat (3) @(negedge clk);
    start = 1'b1; a = 8'h35; b = 8'h12;
    @(negedge clk);
    check("reset_wins_busy", busy, 0);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 8'h00);
    check("reset bout", bout, 0);
    check("reset zero", zero, 0);

    do_op("sub_35_12", 1'b0, 8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
    do_op("sub_00_01", 1'b0, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    do_op("sub_5A_5A", 1'b0, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1);
    do_op("dec_00",    1'b1, 8'h00, 8'hAA, 8'hFF, 1'b1, 1'b0);
    do_op("dec_01",    1'b1, 8'h01, 8'hAA, 8'h00, 1'b0, 1'b1);

    // start pulsed while busy must be ignored
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 8'h80; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'h11; b = 8'h22; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bc);
    check("busy_start latency", cyc + 3, 8);
    check("busy_start result", result, 8'h7F);
    check("busy_start bout", bout, 0);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy === 1'b1 || done === 1'b1) extra++;
    end
    check("busy_start no_second_op", extra, 0);

    // reset mid-operation
    start = 1'b1; mode = 1'b0; a = 8'h35; b = 8'h12;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst result", result, 8'h00);
    check("midrst bout", bout, 0);
    check("midrst zero", zero, 0);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    check("midrst no_done", extra, 0);
    do_op("after_rst", 1'b0, 8'h35, 8'h12, 8'h23, 1'b0, 1'b0);

    // start held high: back-to-back operations every WIDTH+2 cycles
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 8'h10; b = 8'h01;
    n_done = 0; last_done = -1;
    for (int t = 0; t < 60 && n_done < 3; t++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        check("cont result", result, 8'h0F);
        check("cont busy_low", busy, 0);
        if (last_done >= 0) check("cont period", t - last_done, 10);
        last_done = t;
        n_done++;
      end
    end
    check("cont done_count", n_done, 3);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // WIDTH=2 instance
    s2_start = 1'b1; s2_mode = 1'b0; s2_a = 2'b00; s2_b = 2'b01;
    @(negedge clk);
    s2_start = 1'b0; s2_a = 2'b11; s2_b = 2'b11;
    cyc = 0;
    while (s2_done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("w2 latency", cyc, 2);
    check("w2 result", s2_result, 2'b11);
    check("w2 bout", s2_bout, 1);
    check("w2 zero", s2_zero, 0);
    @(negedge clk);
    check("w2 done_one_cycle", s2_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
